// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor slice and a borrow flop,
// iterated WIDTH times per operation, with a parallel result and a done strobe.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q;
   logic [CW-1:0]    cnt_q;
   logic             q_q, borrow_q;
   logic             x, y, d_bit, q_d;

   // Full-subtractor slice on the current LSBs
   assign x     = a_sh_q[0];
   assign y     = b_sh_q[0];
   assign d_bit = x ^ y ^ q_q;
   assign q_d   = (~x & y) | (~(x ^ y) & q_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         q_q      <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sh_q <= a;
                  b_sh_q <= b;
                  q_q    <= 1'b0;
                  cnt_q  <= '0;
               end
            end
            SHIFT: begin
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               res_q  <= {d_bit, res_q[WIDTH-1:1]};
               q_q    <= q_d;
               cnt_q  <= cnt_q + CW'(1);
               // Last slice: publish the result including this bit
               if (cnt_q == LAST) begin
                  diff_q   <= {d_bit, res_q[WIDTH-1:1]};
                  borrow_q <= q_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued when an
// operation is accepted and compared when done is seen.
module tb_serial_subtractor;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, borrow;
   logic [W-1:0] diff;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           busy_cnt = 0;
   int           last_done = 0;
   int           prev_done;
   logic [W-1:0] hold_d;
   logic         hold_b;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: sample on the falling edge, pop and compare on every done
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy && done) chk("busy_done_exclusive", 1, 0);
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               $display("done @%0d: diff=%0d borrow=%0d (exp %0d/%0d @%0d)",
                        cyc, diff, borrow, e.d, e.br, e.cyc);
               chk("diff", 32'(diff), 32'(e.d));
               chk("borrow", 32'(borrow), 32'(e.br));
               chk("latency", cyc, e.cyc);
               chk("busy_cycles", busy_cnt, W);
            end
            last_done = cyc;
            busy_cnt  = 0;
         end
      end
   end

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t x;
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      x.d   = av - bv;
      x.br  = (av < bv);
      x.cyc = cyc + W;
      sb.push_back(x);
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 0, 1);
         sb.delete();
      end
   endtask

   initial begin
      logic [W-1:0] va [6] = '{8'd5, 8'd3, 8'd0, 8'd0, 8'd255, 8'd255};
      logic [W-1:0] vb [6] = '{8'd3, 8'd5, 8'd1, 8'd0, 8'd255, 8'd0};

      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_diff", 32'(diff), 0);
      chk("reset_borrow", 32'(borrow), 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i]);
         wait_done();
      end

      // Start and operand changes while busy must be ignored
      run_op(8'd200, 8'd100);
      repeat (2) @(negedge clk);
      a = 8'd1;
      b = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'd77;
      b = 8'd99;
      wait_done();

      hold_d = diff;
      hold_b = borrow;
      repeat (20) begin
         @(negedge clk);
         chk("hold_diff", 32'(diff), 32'(hold_d));
         chk("hold_borrow", 32'(borrow), 32'(hold_b));
         chk("idle_busy", 32'(busy), 0);
         chk("idle_done", 32'(done), 0);
      end

      // Asynchronous reset between edges mid-operation
      run_op(8'd50, 8'd7);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_diff", 32'(diff), 0);
      chk("abort_borrow", 32'(borrow), 0);
      sb.delete();
      #1;
      rst = 1'b0;
      repeat (12) @(negedge clk);

      run_op(8'd10, 8'd4);
      wait_done();
      prev_done = last_done;
      run_op(8'd128, 8'd1);
      wait_done();
      chk("b2b_gap", last_done - prev_done, W + 2);

      for (int i = 0; i < 6; i++) begin
         run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
         wait_done();
      end
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
